// File: rtl/cu_fsm_irq.sv
// Multi-cycle OTTER control unit: fetch/exec/writeback with memory handshakes and a
// priority-encoded interrupt-entry state. Enables decode combinationally from state and IR.
module cu_fsm_irq #(
   parameter int                 NUM_IRQ  = 1,
   parameter logic [NUM_IRQ-1:0] IRQ_MASK = '1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [6:0]           ir6_0,
   input  logic [2:0]           ir14_12,
   input  logic [11:0]          ir31_20,
   input  logic                 mem_ready,
   input  logic [NUM_IRQ-1:0]   INTR,
   input  logic                 mie,
   output logic                 PCWrite,
   output logic                 regWrite,
   output logic                 memWE2,
   output logic                 memRDEN1,
   output logic                 memRDEN2,
   output logic                 reset,
   output logic                 csr_WE,
   output logic                 int_taken,
   output logic                 mret_exec,
   output logic [((NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1)-1:0] int_cause
);

   localparam int CW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_SYS   = 7'b1110011;

   typedef enum logic [2:0] {
      ST_INIT, ST_FETCH, ST_EXEC, ST_WB, ST_INTR
   } state_t;

   state_t          ps_q, ps_d;
   logic [CW-1:0]   int_cause_q, int_cause_d;
   logic [NUM_IRQ-1:0] active;
   logic [CW-1:0]   lowest;
   logic            pending, done, is_mret;

   assign active  = INTR & IRQ_MASK;
   assign pending = mie & (|active);

   always_comb begin
      lowest = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (active[i]) lowest = CW'(i);
      end
   end

   always_comb begin
      PCWrite   = 1'b0;
      regWrite  = 1'b0;
      memWE2    = 1'b0;
      memRDEN1  = 1'b0;
      memRDEN2  = 1'b0;
      reset     = 1'b0;
      csr_WE    = 1'b0;
      int_taken = 1'b0;
      mret_exec = 1'b0;
      done      = 1'b0;
      is_mret   = 1'b0;
      ps_d      = ps_q;
      case (ps_q)
         ST_INIT: begin
            reset = 1'b1;
            ps_d  = ST_FETCH;
         end
         ST_FETCH: begin
            memRDEN1 = 1'b1;
            if (mem_ready) ps_d = ST_EXEC;
         end
         ST_EXEC: begin
            case (ir6_0)
               OP_LOAD: begin
                  memRDEN2 = 1'b1;
                  ps_d     = ST_WB;
               end
               OP_R, OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
                  regWrite = 1'b1;
                  PCWrite  = 1'b1;
                  done     = 1'b1;
               end
               OP_STORE: begin
                  memWE2 = 1'b1;
                  if (mem_ready) begin
                     PCWrite = 1'b1;
                     done    = 1'b1;
                  end
               end
               OP_SYS: begin
                  PCWrite = 1'b1;
                  done    = 1'b1;
                  if (ir14_12 != 3'b000) begin
                     regWrite = 1'b1;
                     csr_WE   = 1'b1;
                  end else if (ir31_20 == 12'h302) begin
                     mret_exec = 1'b1;
                     is_mret   = 1'b1;
                  end
               end
               // Branches, ECALL/EBREAK and illegal encodings just advance the PC.
               default: begin
                  PCWrite = 1'b1;
                  done    = 1'b1;
               end
            endcase
         end
         ST_WB: begin
            memRDEN2 = 1'b1;
            if (mem_ready) begin
               regWrite = 1'b1;
               PCWrite  = 1'b1;
               done     = 1'b1;
            end
         end
         ST_INTR: begin
            int_taken = 1'b1;
            PCWrite   = 1'b1;
            ps_d      = ST_FETCH;
         end
         default: ps_d = ST_INIT;
      endcase
      // MRET never chains straight into an interrupt so the handler's caller advances.
      if (done) ps_d = (pending && !is_mret) ? ST_INTR : ST_FETCH;
   end

   always_comb begin
      int_cause_d = int_cause_q;
      if (ps_d == ST_INTR && ps_q != ST_INTR) int_cause_d = lowest;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ps_q        <= ST_INIT;
         int_cause_q <= '0;
      end else begin
         ps_q        <= ps_d;
         int_cause_q <= int_cause_d;
      end
   end

   assign int_cause = int_cause_q;

endmodule

// File: tb/tb_cu_fsm_irq.sv
// Cycle-by-cycle bench for cu_fsm_irq (NUM_IRQ=4): expected enable vectors are queued
// as each cycle's inputs are applied and compared when the outputs settle.
module tb_cu_fsm_irq;

   logic        CLK = 1'b0;
   logic        RST;
   logic [6:0]  ir6_0;
   logic [2:0]  ir14_12;
   logic [11:0] ir31_20;
   logic        mem_ready;
   logic [3:0]  INTR;
   logic        mie;
   logic        PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset, csr_WE, int_taken, mret_exec;
   logic [1:0]  int_cause;

   int checks = 0;
   int errors = 0;

   logic [10:0] exp_q[$];
   string       tag_q[$];

   // Vector layout: PCWrite regWrite memWE2 memRDEN1 memRDEN2 reset csr_WE int_taken mret_exec cause[1:0]
   localparam logic [10:0] PCW = 11'h400, RGW = 11'h200, WE2 = 11'h100, RD1 = 11'h080;
   localparam logic [10:0] RD2 = 11'h040, RSO = 11'h020, CSR = 11'h010, ITK = 11'h008;
   localparam logic [10:0] MRT = 11'h004, C1 = 11'h001, C2 = 11'h002;

   localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011, OP_SYS = 7'b1110011, OP_ILL = 7'b1111111;

   cu_fsm_irq #(.NUM_IRQ(4)) dut (
      .CLK(CLK), .RST(RST), .ir6_0(ir6_0), .ir14_12(ir14_12), .ir31_20(ir31_20),
      .mem_ready(mem_ready), .INTR(INTR), .mie(mie),
      .PCWrite(PCWrite), .regWrite(regWrite), .memWE2(memWE2), .memRDEN1(memRDEN1),
      .memRDEN2(memRDEN2), .reset(reset), .csr_WE(csr_WE), .int_taken(int_taken),
      .mret_exec(mret_exec), .int_cause(int_cause)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   // One clock: apply inputs, queue the expected outputs, compare at the falling edge.
   task automatic step(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic [11:0] f12, input logic mr, input logic [3:0] irq,
                       input logic ie, input logic rst, input logic [10:0] exp);
      logic [10:0] obs;
      ir6_0 = op; ir14_12 = f3; ir31_20 = f12; mem_ready = mr; INTR = irq; mie = ie; RST = rst;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      @(negedge CLK);
      obs = {PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset, csr_WE, int_taken,
             mret_exec, int_cause};
      check(tag_q.pop_front(), obs, exp_q.pop_front());
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1; ir6_0 = OP_R; ir14_12 = 3'b000; ir31_20 = 12'h000;
      mem_ready = 1'b1; INTR = 4'b0000; mie = 1'b0;
      @(posedge CLK);
      #1;
      step("rst_hold",    OP_R,     3'd0, 12'h000, 1, 4'b0000, 0, 1, RSO);
      step("init",        OP_R,     3'd0, 12'h000, 1, 4'b0000, 0, 0, RSO);
      step("alu_fetch",   OP_R,     3'd0, 12'h000, 1, 4'b0000, 0, 0, RD1);
      step("alu_exec",    OP_R,     3'd0, 12'h000, 1, 4'b0000, 0, 0, PCW | RGW);
      step("ld_fetch",    OP_LOAD,  3'd2, 12'h000, 1, 4'b0000, 0, 0, RD1);
      step("ld_exec",     OP_LOAD,  3'd2, 12'h000, 1, 4'b0000, 0, 0, RD2);
      step("ld_wb",       OP_LOAD,  3'd2, 12'h000, 1, 4'b0000, 0, 0, RD2 | RGW | PCW);
      for (int i = 0; i < 3; i++)
         step("st_fetch_stall", OP_STORE, 3'd2, 12'h000, 0, 4'b0000, 0, 0, RD1);
      step("st_fetch_go", OP_STORE, 3'd2, 12'h000, 1, 4'b0000, 0, 0, RD1);
      for (int i = 0; i < 2; i++)
         step("st_exec_stall", OP_STORE, 3'd2, 12'h000, 0, 4'b0000, 0, 0, WE2);
      step("st_exec_go",  OP_STORE, 3'd2, 12'h000, 1, 4'b0000, 0, 0, WE2 | PCW);
      // Interrupt pulse confined to a stalled FETCH cycle is never observed at done.
      step("pulse_fetch", OP_I,     3'd0, 12'h000, 0, 4'b1010, 1, 0, RD1);
      step("pulse_fetch2",OP_I,     3'd0, 12'h000, 1, 4'b0000, 1, 0, RD1);
      step("pulse_exec",  OP_I,     3'd0, 12'h000, 1, 4'b0000, 1, 0, PCW | RGW);
      step("irq_fetch",   OP_I,     3'd0, 12'h000, 1, 4'b0000, 1, 0, RD1);
      step("irq_exec",    OP_I,     3'd0, 12'h000, 1, 4'b1010, 1, 0, PCW | RGW);
      step("irq_entry",   OP_I,     3'd0, 12'h000, 1, 4'b1010, 1, 0, PCW | ITK | C1);
      step("irq_after",   OP_I,     3'd0, 12'h000, 1, 4'b1010, 0, 0, RD1 | C1);
      step("nomie_exec",  OP_I,     3'd0, 12'h000, 1, 4'b1010, 0, 0, PCW | RGW | C1);
      step("nomie_fetch", OP_SYS,   3'd1, 12'h000, 1, 4'b1010, 0, 0, RD1 | C1);
      step("csr_exec",    OP_SYS,   3'd1, 12'h000, 1, 4'b0000, 0, 0, PCW | RGW | CSR | C1);
      step("mret_fetch",  OP_SYS,   3'd0, 12'h302, 1, 4'b1010, 1, 0, RD1 | C1);
      step("mret_exec",   OP_SYS,   3'd0, 12'h302, 1, 4'b1010, 1, 0, PCW | MRT | C1);
      step("mret_next",   OP_R,     3'd0, 12'h000, 1, 4'b1010, 1, 0, RD1 | C1);
      step("prio_exec",   OP_R,     3'd0, 12'h000, 1, 4'b1100, 1, 0, PCW | RGW | C1);
      step("prio_entry",  OP_R,     3'd0, 12'h000, 1, 4'b0000, 0, 0, PCW | ITK | C2);
      step("ill_fetch",   OP_ILL,   3'd0, 12'h000, 1, 4'b0000, 0, 0, RD1 | C2);
      step("ill_exec",    OP_ILL,   3'd0, 12'h000, 1, 4'b0000, 0, 0, PCW | C2);
      step("wbr_fetch",   OP_LOAD,  3'd2, 12'h000, 1, 4'b0000, 0, 0, RD1 | C2);
      step("wbr_exec",    OP_LOAD,  3'd2, 12'h000, 1, 4'b0000, 0, 0, RD2 | C2);
      step("wbr_stall",   OP_LOAD,  3'd2, 12'h000, 0, 4'b0000, 0, 0, RD2 | C2);
      step("wbr_rst",     OP_LOAD,  3'd2, 12'h000, 0, 4'b0000, 0, 1, RD2 | C2);
      step("wbr_init",    OP_LOAD,  3'd2, 12'h000, 1, 4'b0000, 0, 0, RSO);
      step("wbr_fetch2",  OP_LOAD,  3'd2, 12'h000, 1, 4'b0000, 0, 0, RD1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cu_fsm_irq.md
# cu_fsm_irq

Multi-cycle control-unit state machine for the OTTER MCU, successor to the single-issue fetch/exec/writeback controller. It adds variable-latency memory handshakes, a dedicated interrupt-entry state with a parametrised, priority-encoded interrupt input vector, and full decode of JAL/JALR, CSR and MRET. It sits between the instruction register and the PC, register file, memory and CSR file, and drives their enables.

## Interface
- NUM_IRQ, default 1: number of interrupt request lines, 1..16.
- IRQ_MASK, default all ones (NUM_IRQ bits): static per-line enable; masked lines are ignored.
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  reset. One clock; reset is synchronous and active-high.
- ir6_0  input  7  opcode field of the current instruction.
- ir14_12  input  3  funct3 field.
- ir31_20  input  12  funct12 field; used for MRET detect, 12'h302.
- mem_ready  input  1  memory has completed the current read or write.
- INTR  input  NUM_IRQ  level-sensitive interrupt requests.
- mie  input  1  global interrupt enable from the CSR file.
- PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset, csr_WE, int_taken, mret_exec  output  1 each  datapath enables.
- int_cause  output  max(1,$clog2(NUM_IRQ))  index of the interrupt line taken; registered.

## Operation
- States: INIT, FETCH, EXEC, WRITEBACK, INTR. Outputs are combinational from the present state and IR fields. The default for every enable is 0.
- INIT: reset=1. Next state is FETCH.
- FETCH: memRDEN1=1. Stays in FETCH while mem_ready=0, with memRDEN1 held high. Goes to EXEC on mem_ready=1.
- EXEC decode (opcode → outputs, then next state "done"):
  - Load (0000011): memRDEN2=1. Next state is WRITEBACK; no PCWrite.
  - R (0110011), I (0010011), LUI (0110111), AUIPC (0010111), JAL (1101111), JALR (1100111): regWrite=1, PCWrite=1.
  - Store (0100011): memWE2=1. If mem_ready=0, stay in EXEC with memWE2 held and no PCWrite. Otherwise PCWrite=1, done.
  - Branch (1100011): PCWrite=1.
  - SYSTEM (1110011), funct3≠0 (CSR op): regWrite=1, csr_WE=1, PCWrite=1.
  - SYSTEM, funct3=0, ir31_20=12'h302 (MRET): mret_exec=1, PCWrite=1.
  - Any other encoding (illegal, ECALL, EBREAK): PCWrite=1 only, treated as a NOP. No register, memory or CSR writes.
- WRITEBACK: memRDEN2=1 held. When mem_ready=1: regWrite=1, PCWrite=1, done. Otherwise stay in WRITEBACK with all writes deasserted.
- pending = mie & |(INTR & IRQ_MASK).
- "done" means: next state is INTR if pending=1 and the completing instruction is not MRET; otherwise FETCH.
- INTR: int_taken=1, PCWrite=1. Next state is FETCH. On entry, int_cause loads the lowest-indexed active unmasked line; it holds until the next INTR entry.
- Interrupts are never taken from INIT or FETCH, or mid-instruction. They are only taken at the done point.

## Timing
- Reset: the cycle after RST is sampled high, PS=INIT. Every output is 0 except reset=1, and int_cause=0.
- RST asserted in any state, including mid-handshake, forces INIT on the next edge. Outstanding memory operations are abandoned.
- Cycles per instruction with zero-wait memory (mem_ready tied 1):
  - Non-load: 2 cycles (FETCH, EXEC).
  - Load: 3 cycles.
  - +1 cycle when an interrupt is taken.
- Each mem_ready=0 cycle in FETCH, store-EXEC or WRITEBACK adds exactly one cycle. Enables are stable throughout the stall.
- PCWrite is high for exactly one cycle per retired instruction and one per interrupt entry.
- INTR asserted and deasserted entirely within a single FETCH cycle is not taken.
- MRET completing while pending=1 returns to FETCH. The interrupt is taken at the end of the following instruction, which guarantees forward progress.
- Simultaneous INTR lines: the lowest index wins.

## Test plan
- Reset: RST=1 for 2 cycles, then 0 → reset=1 for one cycle, then memRDEN1=1 in FETCH. All other outputs 0 and int_cause=0 throughout.
- ALU and load with mem_ready=1: opcodes 0110011 then 0000011 → first is 2 cycles with regWrite and PCWrite in EXEC; second is 3 cycles with memRDEN2 in EXEC and WRITEBACK, regWrite and PCWrite only in WRITEBACK.
- Stalls: mem_ready=0 for 3 cycles during FETCH of a store → FETCH lasts 4 cycles. Then mem_ready=0 for 2 cycles in EXEC → memWE2 high for 3 cycles, PCWrite only in the last.
- Interrupt, NUM_IRQ=4: INTR=4'b1010, mie=1 during an I-type EXEC → next state INTR with int_taken=1, PCWrite=1, int_cause=1, then FETCH. Repeat with mie=0 → no INTR state.
- CSR/MRET decode: 1110011 with funct3=001 → csr_WE=1, regWrite=1. Funct3=000 with ir31_20=12'h302 and INTR pending → mret_exec=1, next state FETCH, not INTR.
- Illegal opcode 1111111 → PCWrite=1 only. RST pulsed during a WRITEBACK stall → INIT on the next cycle with regWrite=0.
